// File: rtl/seq_pattern_detect.sv
// Serial pattern detector: compares the last W sampled bits against a loadable
// pattern, emits a registered one-cycle match pulse and a saturating match count.
module seq_pattern_detect #(
    parameter int              W           = 3,
    parameter int              CNT_W       = 8,
    parameter logic [W-1:0]    DEFAULT_PAT = 3'b010
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             a,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [W-1:0]     pattern_in,
    input  logic             clear,
    output logic             f,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(W);
    localparam logic [FW-1:0]    FILL_ARM  = FW'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [W-1:0]     hist_r;
    logic [W-1:0]     pat_r;
    logic [FW-1:0]    fill_r;
    logic             f_r;
    logic [CNT_W-1:0] cnt_r;

    logic [W-1:0]     shifted_s;
    logic             match_s;
    logic [W-1:0]     hist_nxt_s;
    logic [W-1:0]     pat_nxt_s;
    logic [FW-1:0]    fill_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Match detection: the incoming bit completes the window only once W-1 bits are held.
    always_comb begin
        shifted_s = {hist_r[W-2:0], a};
        match_s   = 1'b0;
        if (en && !load && (shifted_s == pat_r) && (fill_r >= FILL_ARM)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Next-state for history, pattern, fill and counter.
    always_comb begin
        hist_nxt_s = hist_r;
        pat_nxt_s  = pat_r;
        fill_nxt_s = fill_r;
        cnt_nxt_s  = cnt_r;

        if (load) begin
            pat_nxt_s  = pattern_in;
            fill_nxt_s = '0;
        end else if (en) begin
            hist_nxt_s = shifted_s;
            if (match_s && !overlap) begin
                fill_nxt_s = '0;
            end else if (fill_r < FILL_FULL) begin
                fill_nxt_s = fill_r + FW'(1);
            end else begin
                fill_nxt_s = fill_r;
            end
        end else begin
            hist_nxt_s = hist_r;
        end

        // Clear wins over a coincident match; the pulse on f is unaffected.
        if (clear) begin
            cnt_nxt_s = '0;
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            hist_r <= '0;
            pat_r  <= DEFAULT_PAT;
            fill_r <= '0;
            f_r    <= 1'b0;
            cnt_r  <= '0;
        end else begin
            hist_r <= hist_nxt_s;
            pat_r  <= pat_nxt_s;
            fill_r <= fill_nxt_s;
            f_r    <= match_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign f         = f_r;
    assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed bench for seq_pattern_detect: a vector table plus hand-written
// sequences for counter saturation/clear and asynchronous reset.
module tb_seq_pattern_detect;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       a = 1'b0;
    logic       en = 1'b0;
    logic       overlap = 1'b1;
    logic       load = 1'b0;
    logic [2:0] pattern_in = 3'b000;
    logic       clear = 1'b0;
    logic       f8, f2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int tests = 0;
    int failed = 0;

    seq_pattern_detect dut8 (
        .clock(clock), .reset_L(reset_L), .a(a), .en(en), .overlap(overlap),
        .load(load), .pattern_in(pattern_in), .clear(clear),
        .f(f8), .match_cnt(cnt8)
    );

    seq_pattern_detect #(.W(3), .CNT_W(2), .DEFAULT_PAT(3'b010)) dut2 (
        .clock(clock), .reset_L(reset_L), .a(a), .en(en), .overlap(overlap),
        .load(load), .pattern_in(pattern_in), .clear(clear),
        .f(f2), .match_cnt(cnt2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       a;
        logic       ld;
        logic [2:0] pat;
        logic       clr;
        logic       ov;
        logic       ef;
        logic [7:0] ec;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic ai,
                                input logic ld, input logic [2:0] p, input logic cl,
                                input logic ov, input logic ef, input logic [7:0] ec,
                                input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.a = ai; v.ld = ld; v.pat = p; v.clr = cl;
        v.ov = ov; v.ef = ef; v.ec = ec; v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        en = 1'b0; a = 1'b0; load = 1'b0; clear = 1'b0; pattern_in = 3'b000;
        #1;
        check("reset_f", {7'd0, f8}, 8'd0);
        check("reset_cnt", cnt8, 8'd0);
        @(posedge clock);
        #1;
        reset_L = 1'b1;
    endtask

    // Drive one cycle's inputs, clock it, then compare both instances.
    task automatic step(input logic e, input logic ai, input logic ld, input logic [2:0] p,
                        input logic cl, input logic ov, input logic ef, input logic [7:0] ec,
                        input logic [1:0] ec2, input string nm);
        en = e; a = ai; load = ld; pattern_in = p; clear = cl; overlap = ov;
        @(posedge clock);
        #1;
        check({nm, "_f"}, {7'd0, f8}, {7'd0, ef});
        check({nm, "_cnt"}, cnt8, ec);
        check({nm, "_f_w2"}, {7'd0, f2}, {7'd0, ef});
        check({nm, "_cnt_w2"}, {6'd0, cnt2}, {6'd0, ec2});
    endtask

    function automatic logic [1:0] sat2(input int k);
        return (k > 3) ? 2'd3 : k[1:0];
    endfunction

    initial begin
        int k;
        logic [7:0] ec2;

        // rst en a ld pat clr ov ef ec
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 1, 0, 0, "basic1"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "basic2"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 1, "basic3"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 1, "basic4"));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 1, 0, 0, "ov1_b1"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "ov1_b2"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 1, "ov1_b3"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 1, "ov1_b4"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 2, "ov1_b5"));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 0, 0, 0, "ov0_b1"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, "ov0_b2"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 0, 1, 1, "ov0_b3"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 0, 0, 1, "ov0_b4"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 0, 0, 1, "ov0_b5"));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 1, 0, 0, "gap1"));
        vecs.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1, 0, 0, "gap2"));
        vecs.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1, 0, 0, "gap3"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "gap4"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 1, "gap5"));
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 0, 1, 0, 0, "load1"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "load2"));
        vecs.push_back(mk(0, 1, 0, 1, 3'b110, 0, 1, 0, 0, "load_edge"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "load3"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "load4"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 1, "load5"));
        vecs.push_back(mk(0, 0, 1, 1, 3'b010, 1, 1, 0, 0, "ldclr"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 0, 0, "ldclr2"));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 1, 0, 0, "ldclr3"));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 1, 1, "ldclr4"));
        vecs.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1, 0, 1, "en_off"));

        repeat (2) @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            ec2 = (vecs[i].ec > 8'd3) ? 8'd3 : vecs[i].ec;
            step(vecs[i].en, vecs[i].a, vecs[i].ld, vecs[i].pat, vecs[i].clr, vecs[i].ov,
                 vecs[i].ef, vecs[i].ec, ec2[1:0], vecs[i].name);
        end

        // Saturation: 0,1,0,1,... yields matches at bits 3,5,7,9,11.
        do_reset();
        k = 0;
        for (int i = 0; i < 11; i++) begin
            if (i >= 2 && (i % 2) == 0) k++;
            step(1'b1, logic'(i % 2), 1'b0, 3'b000, 1'b0, 1'b1,
                 (i >= 2 && (i % 2) == 0), 8'(k), sat2(k), "sat");
        end
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd5, 2'd3, "sat_gap");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 8'd0, 2'd0, "clr_match");
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "post_clr1");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1, "post_clr2");

        // Async reset while f is high and the count is nonzero.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "ar_a");
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "ar_b");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1, "ar_c");
        #2 reset_L = 1'b0;
        #1;
        check("async_f", {7'd0, f8}, 8'd0);
        check("async_cnt", cnt8, 8'd0);
        #2 reset_L = 1'b1;

        // Partial 0,1 before reset must not complete a match afterwards.
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "pr_a");
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "pr_b");
        #2 reset_L = 1'b0;
        #1;
        check("async2_f", {7'd0, f8}, 8'd0);
        check("async2_cnt", cnt8, 8'd0);
        #2 reset_L = 1'b1;
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "pr_nomatch");
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, "pr_c");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1, "pr_match");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
